sequenciador_vedacao: RTL and testbench

// - Sequences the corking station of the wine conveyor: runs the belt, stops each bottle under the corker,

---
 rtl/sequenciador_vedacao_pkg.sv | 15 +
 rtl/sequenciador_vedacao_filtro_sensor.sv | 18 +
 rtl/sequenciador_vedacao.sv | 78 +++++++
 tb/tb_sequenciador_vedacao.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/sequenciador_vedacao_pkg.sv
// sequenciador_vedacao_pkg: state encoding and counter widths shared by the corking sequencer
package sequenciador_vedacao_pkg;
  localparam int TAM_CAIXA_PADRAO = 12;
  localparam int W_CAIXA = 4;
  localparam int W_TOTAL = 8;
  localparam int W_TEMPO = 8;
  typedef enum logic [2:0] {
    PARADO        = 3'd0,
    TRANSPORTE    = 3'd1,
    PEDE_ROLHA    = 3'd2,
    AGUARDA_ROLHA = 3'd3,
    VEDANDO       = 3'd4,
    LIBERA        = 3'd5
  } estado_t;
endpackage

// File: rtl/sequenciador_vedacao_filtro_sensor.sv
// sequenciador_vedacao_filtro_sensor: flags a bottle once the sensor has been high T_ESTAVEL consecutive cycles
module sequenciador_vedacao_filtro_sensor
  import sequenciador_vedacao_pkg::*;
#(
  parameter int T_ESTAVEL = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic habilita,
  input  logic sensor_garrafa,
  output logic garrafa_posicionada
);
  logic [W_TEMPO-1:0] cnt;
  assign garrafa_posicionada = habilita && sensor_garrafa && cnt == W_TEMPO'(T_ESTAVEL - 1);
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else cnt <= (habilita && sensor_garrafa && !garrafa_posicionada) ? cnt + 1'b1 : '0;
endmodule

// File: rtl/sequenciador_vedacao.sv
// sequenciador_vedacao: corking station sequencer driving belt, cork request, press and box/total counters
module sequenciador_vedacao
  import sequenciador_vedacao_pkg::*;
#(
  parameter int T_ESTAVEL = 4,
  parameter int T_VEDACAO = 8,
  parameter int TAM_CAIXA = TAM_CAIXA_PADRAO
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic               sensor_garrafa,
  input  logic               rolha_disponivel,
  input  logic               disp_acionado,
  input  logic               LED_Alarme,
  output logic               motor_esteira,
  output logic               dec_rolha,
  output logic               atuador_vedacao,
  output logic               aguardando_rolha,
  output logic               duzia_completa,
  output logic [W_CAIXA-1:0] garrafas_caixa,
  output logic [W_TOTAL-1:0] total_vedadas,
  output logic [2:0]         estado
);
  estado_t st, prox;
  logic posicionada, stop_lat, fim_vedacao, caixa_cheia;
  logic [W_TEMPO-1:0] t_ved;
  sequenciador_vedacao_filtro_sensor #(.T_ESTAVEL(T_ESTAVEL)) u_filtro (
    .clk                 (clk),
    .reset               (reset),
    .habilita            (st == TRANSPORTE),
    .sensor_garrafa      (sensor_garrafa),
    .garrafa_posicionada (posicionada)
  );
  assign fim_vedacao = st == VEDANDO && t_ved == W_TEMPO'(T_VEDACAO - 1);
  assign caixa_cheia = garrafas_caixa == W_CAIXA'(TAM_CAIXA - 1);
  assign estado = st;
  // A bottle under the press never leaves uncorked: AGUARDA_ROLHA and VEDANDO ignore stop.
  always_comb begin
    prox = PARADO;
    case (st)
      PARADO:        prox = (start && !stop) ? TRANSPORTE : PARADO;
      TRANSPORTE:    prox = stop ? PARADO : posicionada ? PEDE_ROLHA : TRANSPORTE;
      PEDE_ROLHA:    prox = (!rolha_disponivel || LED_Alarme) ? AGUARDA_ROLHA : disp_acionado ? PEDE_ROLHA : VEDANDO;
      AGUARDA_ROLHA: prox = (rolha_disponivel && !LED_Alarme) ? PEDE_ROLHA : AGUARDA_ROLHA;
      VEDANDO:       prox = fim_vedacao ? LIBERA : VEDANDO;
      LIBERA:        prox = sensor_garrafa ? LIBERA : (stop_lat || stop) ? PARADO : TRANSPORTE;
      default:       prox = PARADO;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      st               <= PARADO;
      stop_lat         <= 1'b0;
      t_ved            <= '0;
      motor_esteira    <= 1'b0;
      dec_rolha        <= 1'b0;
      atuador_vedacao  <= 1'b0;
      aguardando_rolha <= 1'b0;
      duzia_completa   <= 1'b0;
      garrafas_caixa   <= '0;
      total_vedadas    <= '0;
    end else begin
      st               <= prox;
      motor_esteira    <= prox == TRANSPORTE || prox == LIBERA;
      atuador_vedacao  <= prox == VEDANDO;
      aguardando_rolha <= prox == AGUARDA_ROLHA;
      dec_rolha        <= st == PEDE_ROLHA && prox == VEDANDO;
      stop_lat         <= prox == PARADO ? 1'b0 : stop_lat || (st == VEDANDO && stop);
      t_ved            <= (st == VEDANDO && !fim_vedacao) ? t_ved + 1'b1 : '0;
      duzia_completa   <= fim_vedacao && caixa_cheia;
      if (fim_vedacao) begin
        garrafas_caixa <= caixa_cheia ? '0 : garrafas_caixa + 1'b1;
        total_vedadas  <= (&total_vedadas) ? total_vedadas : total_vedadas + 1'b1;
      end
    end
endmodule

// File: tb/tb_sequenciador_vedacao.sv
// tb_sequenciador_vedacao: random bottle traffic against a counting model, scoreboarded at each press release
module tb_sequenciador_vedacao;
  logic clk = 0, reset = 1, start = 0, stop = 0, sensor_garrafa = 0;
  logic rolha_disponivel = 1, disp_acionado = 0, LED_Alarme = 0;
  logic motor_esteira, dec_rolha, atuador_vedacao, aguardando_rolha, duzia_completa;
  logic [3:0] garrafas_caixa;
  logic [7:0] total_vedadas;
  logic [2:0] estado;

  sequenciador_vedacao dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .sensor_garrafa(sensor_garrafa),
    .rolha_disponivel(rolha_disponivel), .disp_acionado(disp_acionado), .LED_Alarme(LED_Alarme),
    .motor_esteira(motor_esteira), .dec_rolha(dec_rolha), .atuador_vedacao(atuador_vedacao),
    .aguardando_rolha(aguardando_rolha), .duzia_completa(duzia_completa),
    .garrafas_caixa(garrafas_caixa), .total_vedadas(total_vedadas), .estado(estado)
  );

  always #5 clk = ~clk;

  typedef struct {int tot; int cx; int dz;} exp_t;
  exp_t q[$];
  int total = 0, bad = 0;
  int n = 0, dec_exp = 0, dec_seen = 0, dz_exp = 0, dz_seen = 0;

  task automatic chk(string nm, int act, int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endtask

  // Model: the n-th corked bottle since reset gives total=min(n,255), box=n mod 12, dozen pulse when n mod 12 == 0
  task automatic espera_vedar();
    exp_t e;
    n++;
    dec_exp++;
    e.tot = n > 255 ? 255 : n;
    e.cx = n % 12;
    e.dz = (n % 12 == 0) ? 1 : 0;
    dz_exp += e.dz;
    q.push_back(e);
  endtask

  task automatic wait_estado(int s, int lim);
    bit ok = 0;
    for (int i = 0; i < lim && !ok; i++) begin
      @(negedge clk);
      ok = (estado == 3'(s));
    end
    if (!ok) chk("timeout_estado", int'(estado), s);
  endtask

  // monitor: scoreboard pops on each press release
  logic atu_q = 0;
  bit pend = 0;
  int atu_len = 0;
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      atu_q = 0; pend = 0; atu_len = 0;
    end else begin
      if (dec_rolha) begin
        dec_seen++;
        chk("dec_sem_vedacao", int'(pend), 0);
        pend = 1;
      end
      if (duzia_completa) dz_seen++;
      if (atuador_vedacao) atu_len++;
      if (atu_q && !atuador_vedacao) begin
        chk("atuador_ciclos", atu_len, 8);
        atu_len = 0;
        pend = 0;
        if (q.size() == 0) chk("fila_vazia", q.size(), 1);
        else begin
          e = q.pop_front();
          chk("total_vedadas", int'(total_vedadas), e.tot);
          chk("garrafas_caixa", int'(garrafas_caixa), e.cx);
          chk("duzia_completa", int'(duzia_completa), e.dz);
        end
      end
      atu_q = atuador_vedacao;
    end
  end

  // modo: 0 normal, 1 no cork, 2 alarm, 3 recharge busy for dcy cycles
  task automatic garrafa(int modo, int dcy);
    int d0;
    @(negedge clk);
    rolha_disponivel = (modo != 1);
    LED_Alarme = (modo == 2);
    disp_acionado = (modo == 3);
    sensor_garrafa = 1;
    wait_estado(2, 10);
    chk("motor_parado_pede", int'(motor_esteira), 0);
    if (modo == 1 || modo == 2) begin
      d0 = dec_seen;
      wait_estado(3, 3);
      chk("aguardando_rolha", int'(aguardando_rolha), 1);
      chk("motor_aguarda", int'(motor_esteira), 0);
      repeat (3) @(negedge clk);
      chk("estado_aguarda", int'(estado), 3);
      chk("dec_em_aguarda", dec_seen, d0);
      rolha_disponivel = 1;
      LED_Alarme = 0;
    end else if (modo == 3) begin
      for (int i = 0; i < dcy; i++) begin
        if (i > 0) @(negedge clk);
        chk("espera_recarga", int'(estado), 2);
        chk("dec_na_recarga", int'(dec_rolha), 0);
      end
      disp_acionado = 0;
    end
    espera_vedar();
    wait_estado(5, 40);
    chk("motor_libera", int'(motor_esteira), 1);
    sensor_garrafa = 0;
    wait_estado(1, 5);
  endtask

  task automatic glitch(int k);
    @(negedge clk);
    sensor_garrafa = 1;
    repeat (k) @(negedge clk);
    sensor_garrafa = 0;
    repeat (2) @(negedge clk);
    chk("glitch_estado", int'(estado), 1);
    chk("glitch_motor", int'(motor_esteira), 1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_estado", int'(estado), 0);
    chk("rst_motor", int'(motor_esteira), 0);
    chk("rst_dec", int'(dec_rolha), 0);
    chk("rst_atuador", int'(atuador_vedacao), 0);
    chk("rst_aguardando", int'(aguardando_rolha), 0);
    chk("rst_duzia", int'(duzia_completa), 0);
    chk("rst_caixa", int'(garrafas_caixa), 0);
    chk("rst_total", int'(total_vedadas), 0);
    reset = 0;
    repeat (2) @(negedge clk);
    chk("parado_sem_start", int'(estado), 0);
    start = 1;
    wait_estado(1, 3);
    glitch(3);
    chk("glitch_sem_dec", dec_seen, 0);
    garrafa(0, 0);
    garrafa(1, 0);
    garrafa(3, 3);
    garrafa(2, 0);
    while (n < 260) begin
      int r = $urandom_range(0, 9);
      if ($urandom_range(0, 7) == 0) glitch($urandom_range(1, 3));
      garrafa(r == 0 ? 1 : r == 1 ? 2 : r == 2 ? 3 : 0, $urandom_range(1, 4));
    end
    chk("total_saturado", int'(total_vedadas), 255);
    chk("caixa_final", int'(garrafas_caixa), n % 12);
    @(negedge clk);
    sensor_garrafa = 1;
    wait_estado(4, 10);
    stop = 1;
    @(negedge clk);
    stop = 0;
    espera_vedar();
    wait_estado(5, 20);
    sensor_garrafa = 0;
    wait_estado(0, 5);
    chk("stop_motor", int'(motor_esteira), 0);
    wait_estado(1, 5);
    @(negedge clk);
    sensor_garrafa = 1;
    wait_estado(4, 10);
    repeat (3) @(negedge clk);
    dec_exp++;
    reset = 1;
    #1;
    chk("rstv_estado", int'(estado), 0);
    chk("rstv_atuador", int'(atuador_vedacao), 0);
    chk("rstv_motor", int'(motor_esteira), 0);
    chk("rstv_total", int'(total_vedadas), 0);
    chk("rstv_caixa", int'(garrafas_caixa), 0);
    n = 0;
    sensor_garrafa = 0;
    @(negedge clk);
    reset = 0;
    wait_estado(1, 5);
    garrafa(0, 0);
    repeat (5) @(negedge clk);
    chk("dec_total", dec_seen, dec_exp);
    chk("duzias_total", dz_seen, dz_exp);
    chk("fila_pendente", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
